// File: rtl/led_mode_pkg.sv
// -----------------------------------------------------------------------------
// led_mode_pkg
//   Shared types for the LED mode controller.
//   mode_t    : the four LED modes, in button-press order
//   next_mode : mode reached after one accepted press (wraps FAST -> OFF)
// -----------------------------------------------------------------------------
package led_mode_pkg;

   typedef enum logic [1:0] {
      MODE_OFF  = 2'd0,
      MODE_ON   = 2'd1,
      MODE_SLOW = 2'd2,
      MODE_FAST = 2'd3
   } mode_t;

   function automatic mode_t next_mode(input mode_t m);
      mode_t n;
      unique case (m)
         MODE_OFF:  n = MODE_ON;
         MODE_ON:   n = MODE_SLOW;
         MODE_SLOW: n = MODE_FAST;
         default:   n = MODE_OFF;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//   Synchronises an asynchronous active-low push button, debounces it and
//   emits a one-cycle strobe for every accepted press (stable 1 -> 0).
//   Releases are debounced the same way but produce no strobe.
//
//   Parameters
//     DEBOUNCE_CYCLES : consecutive cycles the synced button must differ from
//                       the stable level before the change is accepted (>= 2)
//   Ports
//     clk         in   system clock
//     rst         in   synchronous active-high reset
//     btn_n       in   raw button, active-low, asynchronous
//     press_pulse out  registered one-cycle strobe per accepted press
// -----------------------------------------------------------------------------
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_n,
   output logic press_pulse
);

   localparam int unsigned      CW       = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]    CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 2) begin : g_bad_param
      $error("btn_debounce: DEBOUNCE_CYCLES must be >= 2");
   end

   logic [1:0]    sync_q;
   logic          btn_s;
   logic          stable_q, stable_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          press_q, press_d;

   assign btn_s = sync_q[1];

   // The counter only survives while every cycle still disagrees with the
   // stable level; any agreeing sample restarts the qualification window.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      press_d  = 1'b0;
      if (btn_s != stable_q) begin
         if (cnt_q == CNT_LAST) begin
            stable_d = btn_s;
            press_d  = ~btn_s;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q   <= '1;
         stable_q <= 1'b1;
         cnt_q    <= '0;
         press_q  <= 1'b0;
      end else begin
         sync_q   <= {sync_q[0], btn_n};
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         press_q  <= press_d;
      end
   end

   assign press_pulse = press_q;

endmodule

// File: rtl/led_mode_ctrl.sv
// -----------------------------------------------------------------------------
// led_mode_ctrl
//   Steps the board's two user LEDs through OFF -> ON -> SLOW blink ->
//   FAST blink -> OFF, one step per debounced button press.
//
//   Optional build macro: LED_MODE_PWM_EN
//     defined   : adds the brightness port and a free-running PWM counter;
//                 each LED is gated by (pwm_cnt < brightness)
//     undefined : no brightness port, LEDs driven at full on
//
//   Parameters
//     DEBOUNCE_CYCLES : debounce qualification length in cycles (>= 2)
//     SLOW_HALF       : SLOW blink half period in cycles (>= 2)
//     FAST_HALF       : FAST blink half period in cycles (>= 2, < SLOW_HALF)
//     PWM_BITS        : PWM counter width (only used with LED_MODE_PWM_EN)
//   Ports
//     clk         in   system clock
//     rst         in   synchronous active-high reset
//     btn_n       in   raw push button, active-low, asynchronous
//     brightness  in   PWM duty (LED_MODE_PWM_EN only)
//     led_a       out  primary LED, registered
//     led_b       out  secondary LED, registered
//     mode_o      out  current mode, registered
//     press_pulse out  one-cycle strobe per accepted press
// -----------------------------------------------------------------------------
module led_mode_ctrl
   import led_mode_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned SLOW_HALF       = 50_000_000,
   parameter int unsigned FAST_HALF       = 12_500_000,
   parameter int unsigned PWM_BITS        = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                btn_n,
`ifdef LED_MODE_PWM_EN
   input  logic [PWM_BITS-1:0] brightness,
`endif
   output logic                led_a,
   output logic                led_b,
   output mode_t               mode_o,
   output logic                press_pulse
);

   localparam int unsigned   BW        = $clog2(SLOW_HALF);
   localparam logic [BW-1:0] SLOW_LAST = BW'(SLOW_HALF - 1);
   localparam logic [BW-1:0] FAST_LAST = BW'(FAST_HALF - 1);

   if (DEBOUNCE_CYCLES < 2 || SLOW_HALF < 2 || FAST_HALF < 2 ||
       FAST_HALF >= SLOW_HALF || PWM_BITS < 1) begin : g_bad_param
      $error("led_mode_ctrl: parameter outside legal range");
   end

   logic          press;
   mode_t         mode_q;
   logic [BW-1:0] blink_cnt_q;
   logic          phase_q;
   logic [BW-1:0] half_last;
   logic          dec_a, dec_b;
   logic          pwm_on;
   logic          led_a_q, led_b_q;

   btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk        (clk),
      .rst        (rst),
      .btn_n      (btn_n),
      .press_pulse(press)
   );

   assign half_last = (mode_q == MODE_FAST) ? FAST_LAST : SLOW_LAST;

   // Mode FSM and blink timer share one register block so that a mode change
   // and the timer restart (phase = 1, led_a first) land on the same edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q      <= MODE_OFF;
         blink_cnt_q <= '0;
         phase_q     <= 1'b1;
      end else if (press) begin
         mode_q      <= next_mode(mode_q);
         blink_cnt_q <= '0;
         phase_q     <= 1'b1;
      end else if (mode_q == MODE_SLOW || mode_q == MODE_FAST) begin
         if (blink_cnt_q == half_last) begin
            blink_cnt_q <= '0;
            phase_q     <= ~phase_q;
         end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
         end
      end else begin
         blink_cnt_q <= '0;
         phase_q     <= 1'b1;
      end
   end

   always_comb begin
      dec_a = 1'b0;
      dec_b = 1'b0;
      unique case (mode_q)
         MODE_OFF: begin
            dec_a = 1'b0;
            dec_b = 1'b0;
         end
         MODE_ON: begin
            dec_a = 1'b1;
            dec_b = 1'b0;
         end
         default: begin
            dec_a = phase_q;
            dec_b = ~phase_q;
         end
      endcase
   end

`ifdef LED_MODE_PWM_EN
   logic [PWM_BITS-1:0] pwm_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         pwm_q <= '0;
      end else begin
         pwm_q <= pwm_q + 1'b1;
      end
   end

   assign pwm_on = (pwm_q < brightness);
`else
   assign pwm_on = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         led_a_q <= 1'b0;
         led_b_q <= 1'b0;
      end else begin
         led_a_q <= dec_a & pwm_on;
         led_b_q <= dec_b & pwm_on;
      end
   end

   assign led_a       = led_a_q;
   assign led_b       = led_b_q;
   assign mode_o      = mode_q;
   assign press_pulse = press;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_led_mode_ctrl
//   Self-checking bench for led_mode_ctrl with DEBOUNCE_CYCLES=4,
//   SLOW_HALF=8, FAST_HALF=2 (PWM_BITS=2 when LED_MODE_PWM_EN is defined).
//   The reference model works from the behavioural rules: a two-sample delay
//   line, a window of the last DEBOUNCE_CYCLES synced samples, a press count
//   for the mode, and elapsed-time arithmetic for the blink phase.
// -----------------------------------------------------------------------------
module tb_led_mode_ctrl;
   import led_mode_pkg::*;

   localparam int DB = 4;
   localparam int SH = 8;
   localparam int FH = 2;
   localparam int PB = 2;

   logic  clk   = 1'b0;
   logic  rst   = 1'b1;
   logic  btn_n = 1'b1;
`ifdef LED_MODE_PWM_EN
   logic [PB-1:0] brightness = '1;
`endif
   logic  led_a, led_b, press_pulse;
   mode_t mode_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   led_mode_ctrl #(
      .DEBOUNCE_CYCLES(DB),
      .SLOW_HALF      (SH),
      .FAST_HALF      (FH),
      .PWM_BITS       (PB)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .btn_n      (btn_n),
`ifdef LED_MODE_PWM_EN
      .brightness (brightness),
`endif
      .led_a      (led_a),
      .led_b      (led_b),
      .mode_o     (mode_o),
      .press_pulse(press_pulse)
   );

   // ---------------- reference model ----------------
   bit dly[$];
   bit win[$];
   bit m_stable = 1'b1, m_press = 1'b0, m_phase = 1'b1, m_a = 1'b0, m_b = 1'b0;
   int m_mode = 0, m_edge = 0, m_t0 = 0, m_pwm = 0;

   function automatic logic [4:0] exp_vec();
      return {m_press, 2'(m_mode), m_a, m_b};
   endfunction

   function automatic logic [4:0] obs_vec();
      return {press_pulse, mode_o, led_a, led_b};
   endfunction

   // Advance one clock, update the model from the inputs seen at that edge,
   // then settle 1 time unit so DUT outputs are sampled away from the edge.
   task automatic step();
      bit bs_pre, all_diff, ppress, pph, gate;
      int pm, half;
`ifdef LED_MODE_PWM_EN
      int ppwm;
`endif
      @(posedge clk);
      bs_pre = (dly.size() > 0) ? dly[0] : 1'b1;
      ppress = m_press;
      pm     = m_mode;
      pph    = m_phase;
`ifdef LED_MODE_PWM_EN
      ppwm   = m_pwm;
`endif
      m_edge++;
      if (rst) begin
         dly.delete();
         dly.push_back(1'b1);
         dly.push_back(1'b1);
         win.delete();
         m_stable = 1'b1;
         m_press  = 1'b0;
         m_mode   = 0;
         m_t0     = m_edge;
         m_phase  = 1'b1;
         m_a      = 1'b0;
         m_b      = 1'b0;
         m_pwm    = 0;
      end else begin
         dly.push_back(btn_n);
         void'(dly.pop_front());
         win.push_back(bs_pre);
         if (win.size() > DB) void'(win.pop_front());
         all_diff = (win.size() == DB);
         foreach (win[i]) if (win[i] == m_stable) all_diff = 1'b0;
         m_press = 1'b0;
         if (all_diff) begin
            m_stable = ~m_stable;
            win.delete();
            m_press  = ~m_stable;
         end
         if (ppress) begin
            m_mode = (pm + 1) % 4;
            m_t0   = m_edge;
         end
         half    = (m_mode == 3) ? FH : SH;
         m_phase = (m_mode >= 2) ? (((m_edge - m_t0) / half) % 2 == 0) : 1'b1;
         gate    = 1'b1;
`ifdef LED_MODE_PWM_EN
         gate    = (ppwm < int'(brightness));
         m_pwm   = (m_pwm + 1) % (1 << PB);
`endif
         m_a = gate && (pm == 1 || (pm >= 2 && pph));
         m_b = gate && (pm >= 2 && !pph);
      end
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst   = 1'b1;
      btn_n = 1'b1;
      repeat (3) begin
         step();
         checks++;
         if (obs_vec() !== 5'b0) begin
            errors++;
            $display("FAIL reset cyc=%0d got=%b exp=%b", m_edge, obs_vec(), 5'b0);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_bounce();
      int pulses = 0;
      for (int it = 0; it < 6; it++) begin
         btn_n = 1'b0;
         repeat ((it == 0) ? 3 : $urandom_range(1, DB - 1)) begin
            step();
            if (press_pulse === 1'b1) pulses++;
            checks++;
            if (obs_vec() !== exp_vec()) begin
               errors++;
               $display("FAIL bounce cyc=%0d got=%b exp=%b", m_edge, obs_vec(), exp_vec());
            end
         end
         btn_n = 1'b1;
         repeat ($urandom_range(2, 6)) begin
            step();
            if (press_pulse === 1'b1) pulses++;
            checks++;
            if (obs_vec() !== exp_vec()) begin
               errors++;
               $display("FAIL bounce cyc=%0d got=%b exp=%b", m_edge, obs_vec(), exp_vec());
            end
         end
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL bounce_pulses got=%0d exp=0", pulses);
      end
      checks++;
      if (mode_o !== MODE_OFF) begin
         errors++;
         $display("FAIL bounce_mode got=%0d exp=%0d", mode_o, MODE_OFF);
      end
   endtask

   task automatic test_clean_press();
      int    p = -1;
      int    pulses = 0;
      mode_t mh[20];
      logic  ah[20];
      logic  bh[20];
      btn_n = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (i == 10) btn_n = 1'b1;
         step();
         mh[i] = mode_o;
         ah[i] = led_a;
         bh[i] = led_b;
         if (press_pulse === 1'b1) begin
            pulses++;
            if (p < 0) p = i;
         end
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL press cyc=%0d got=%b exp=%b", m_edge, obs_vec(), exp_vec());
         end
      end
      checks++;
      if (pulses != 1) begin
         errors++;
         $display("FAIL press_count got=%0d exp=1", pulses);
      end
      // first low sample at edge 1, synced at edge 2, accepted DB samples later
      checks++;
      if (p != DB + 1) begin
         errors++;
         $display("FAIL press_latency got=%0d exp=%0d", p, DB + 1);
      end
      if (p >= 0 && p + 2 < 20) begin
         checks++;
         if (mh[p] !== MODE_OFF || mh[p + 1] !== MODE_ON) begin
            errors++;
            $display("FAIL press_mode got=%0d,%0d exp=0,1", mh[p], mh[p + 1]);
         end
         checks++;
         if ({ah[p + 1], ah[p + 2], bh[p + 2]} !== 3'b010) begin
            errors++;
            $display("FAIL press_led got=%b exp=010", {ah[p + 1], ah[p + 2], bh[p + 2]});
         end
      end
   endtask

   task automatic test_blink_wrap();
      mode_t targets[3] = '{MODE_SLOW, MODE_FAST, MODE_OFF};
      for (int t = 0; t < 3; t++) begin
         btn_n = 1'b0;
         for (int i = 0; i < 50; i++) begin
            if (i == 10) btn_n = 1'b1;
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
               errors++;
               $display("FAIL blink%0d cyc=%0d got=%b exp=%b", t, m_edge, obs_vec(), exp_vec());
            end
            if (mode_o == MODE_SLOW || mode_o == MODE_FAST) begin
               checks++;
               if (led_b !== ~led_a) begin
                  errors++;
                  $display("FAIL blink_compl cyc=%0d got a=%b b=%b", m_edge, led_a, led_b);
               end
            end
         end
         checks++;
         if (mode_o !== targets[t]) begin
            errors++;
            $display("FAIL blink_mode%0d got=%0d exp=%0d", t, mode_o, targets[t]);
         end
      end
   endtask

   task automatic test_random();
      int n = 0;
      bit v = 1'b1;
      while (n < 500) begin
         v     = ~v;
         btn_n = v;
         repeat ($urandom_range(1, 9)) begin
            step();
            n++;
            checks++;
            if (obs_vec() !== exp_vec()) begin
               errors++;
               $display("FAIL random cyc=%0d got=%b exp=%b", m_edge, obs_vec(), exp_vec());
            end
         end
      end
      btn_n = 1'b1;
      repeat (10) begin
         step();
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL random cyc=%0d got=%b exp=%b", m_edge, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_reset_mid_blink();
      int p = -1;
      for (int k = 0; k < 4 && m_mode != 3; k++) begin
         btn_n = 1'b0;
         for (int i = 0; i < 20; i++) begin
            if (i == 10) btn_n = 1'b1;
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
               errors++;
               $display("FAIL midrst_pre cyc=%0d got=%b exp=%b", m_edge, obs_vec(), exp_vec());
            end
         end
      end
      checks++;
      if (mode_o !== MODE_FAST) begin
         errors++;
         $display("FAIL midrst_fast got=%0d exp=%0d", mode_o, MODE_FAST);
      end
      btn_n = 1'b0;
      rst   = 1'b1;
      step();
      checks++;
      if (obs_vec() !== 5'b0) begin
         errors++;
         $display("FAIL midrst_reset got=%b exp=%b", obs_vec(), 5'b0);
      end
      rst = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (press_pulse === 1'b1 && p < 0) p = i;
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL midrst cyc=%0d got=%b exp=%b", m_edge, obs_vec(), exp_vec());
         end
      end
      checks++;
      if (p != DB + 2) begin
         errors++;
         $display("FAIL midrst_latency got=%0d exp=%0d", p, DB + 2);
      end
      checks++;
      if (mode_o !== MODE_ON) begin
         errors++;
         $display("FAIL midrst_mode got=%0d exp=%0d", mode_o, MODE_ON);
      end
      btn_n = 1'b1;
      repeat (10) step();
   endtask

`ifdef LED_MODE_PWM_EN
   task automatic test_pwm();
      int lvl[3] = '{1, 3, 0};
      int highs;
      for (int k = 0; k < 4 && m_mode != 1; k++) begin
         btn_n = 1'b0;
         for (int i = 0; i < 20; i++) begin
            if (i == 10) btn_n = 1'b1;
            step();
         end
      end
      checks++;
      if (mode_o !== MODE_ON) begin
         errors++;
         $display("FAIL pwm_mode got=%0d exp=%0d", mode_o, MODE_ON);
      end
      for (int j = 0; j < 3; j++) begin
         brightness = PB'(lvl[j]);
         step();
         highs = 0;
         repeat (8) begin
            step();
            if (led_a === 1'b1) highs++;
            checks++;
            if (obs_vec() !== exp_vec()) begin
               errors++;
               $display("FAIL pwm cyc=%0d got=%b exp=%b", m_edge, obs_vec(), exp_vec());
            end
         end
         checks++;
         if (highs != 2 * lvl[j]) begin
            errors++;
            $display("FAIL pwm_duty b=%0d got=%0d exp=%0d", lvl[j], highs, 2 * lvl[j]);
         end
      end
      brightness = '1;
   endtask
`endif

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_bounce();
      test_clean_press();
      test_blink_wrap();
      test_random();
      test_reset_mid_blink();
`ifdef LED_MODE_PWM_EN
      test_pwm();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/led_mode_ctrl.md
Name: led_mode_ctrl

Overview:
Mode controller that sequences the board's two user LEDs from a single push button. The button is active-low and asynchronous. The block synchronizes and debounces it, then turns each clean press into a one-cycle event. Each event steps a 4-state mode FSM (OFF, ON, SLOW blink, FAST blink), and a blink timer drives the LED pair from that mode. It sits between the raw board I/O (button in, LEDs out) and replaces direct button-to-LED wiring.

Parameters:
DEBOUNCE_CYCLES, 1_000_000, cycles the synced button must differ from its stable level before the change is accepted (10 ms at 100 MHz); legal range >= 2
SLOW_HALF, 50_000_000, SLOW-mode half period in cycles; legal range >= 2
FAST_HALF, 12_500_000, FAST-mode half period in cycles; legal range >= 2, < SLOW_HALF
PWM_BITS, 4, PWM counter width; used only with LED_MODE_PWM_EN

Ports:
clk  in  1  system clock, all logic rising-edge
rst  in  1  synchronous active-high reset
btn_n  in  1  raw push button, active-low, asynchronous to clk
led_a  out  1  primary LED, registered
led_b  out  1  secondary LED, registered
mode_o  out  2  current mode (led_mode_pkg::mode_t), registered
press_pulse  out  1  one-cycle strobe per accepted press
brightness  in  PWM_BITS  PWM duty; port exists only when LED_MODE_PWM_EN is defined

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. All state is cleared on any clk edge with rst=1.
- Reset values: led_a=0, led_b=0, mode_o=MODE_OFF, press_pulse=0. Synchronizer flops = 1, stable level = 1 (released), all counters = 0, blink phase = 1.
- Sync: 2-flop synchronizer on btn_n, giving btn_s with 2-cycle latency.
- Debounce:
  - If btn_s == stable level, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 while still differing, stable takes btn_s and the counter clears.
  - A mismatch lasting fewer than DEBOUNCE_CYCLES consecutive cycles is ignored.
- Press: press_pulse=1 for exactly one cycle on a stable 1->0 transition. Release (0->1) produces no pulse.
- Mode FSM:
  - Transitions occur only on press_pulse: OFF->ON->SLOW->FAST->OFF (wraps).
  - A press in cycle N updates mode_o at edge N+1.
- Blink timer:
  - In OFF/ON: counter held at 0, phase held at 1.
  - In SLOW/FAST: counter runs 0..HALF-1 with HALF = SLOW_HALF or FAST_HALF. At HALF-1 it returns to 0 and phase toggles.
  - On any mode change the counter clears and phase is set to 1, so blinking always starts with led_a lit.
- LED decode (registered, one cycle after mode/phase):
  - OFF: a=0, b=0
  - ON: a=1, b=0
  - SLOW/FAST: a=phase, b=~phase
  - Net press-to-LED latency: 2 cycles after press_pulse.
- Button held low across reset release: stable restarts at released, so exactly one press is accepted DEBOUNCE_CYCLES+2 cycles later. This is defined behaviour.
- Reset mid-blink: the outputs show reset values on the cycle after the reset edge. Nothing is retained.
- Elaboration check: halt with an error if any parameter is outside its legal range.

Optional Feature:
LED_MODE_PWM_EN
- Defined:
  - brightness port present, plus a free-running PWM_BITS counter cleared by rst.
  - Each LED output = decoded value AND (pwm_cnt < brightness).
  - brightness=0 forces both LEDs off; brightness=2^PWM_BITS-1 gives (2^PWM_BITS-1)/2^PWM_BITS duty.
- Undefined: no brightness port and no PWM counter; LEDs are driven at full on.

Decomposition:
- Package led_mode_pkg:
  - typedef enum logic [1:0] mode_t {MODE_OFF=0, MODE_ON=1, MODE_SLOW=2, MODE_FAST=3}
  - function next_mode(mode_t) implementing the wrap sequence
- Sub-module btn_debounce: synchronizer, debounce counter and press strobe. Parameter DEBOUNCE_CYCLES; ports clk, rst, btn_n, press_pulse.
- Top level holds the FSM, blink timer, decode and optional PWM.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, SLOW_HALF=8, FAST_HALF=2.
- Reset: rst=1 for 3 cycles with btn_n=1 -> led_a=0, led_b=0, mode_o=0, press_pulse never high.
- Bounce: btn_n low 3 cycles then high -> no press_pulse, mode_o stays MODE_OFF.
- Clean press: btn_n low 10 cycles, then high 10 cycles -> exactly one press_pulse; mode_o=MODE_ON next cycle; led_a=1, led_b=0 two cycles after the pulse.
- Blink and wrap:
  - Second press -> MODE_SLOW; led_a starts high and toggles every 8 cycles; led_b is always its complement.
  - Third press -> MODE_FAST; toggle every 2 cycles.
  - Fourth press -> MODE_OFF; both LEDs 0.
- Reset mid-blink: assert rst in FAST while btn_n=0 -> the cycle after the reset edge shows outputs 0 and mode OFF. After rst falls with btn_n held low, one press_pulse arrives 6 cycles later and mode_o becomes MODE_ON.
- PWM (LED_MODE_PWM_EN, PWM_BITS=2), mode ON:
  - brightness=1 -> led_a high 1 of every 4 cycles
  - brightness=3 -> high 3 of every 4 cycles
  - brightness=0 -> constant 0
